// File: rtl/serial_tx.sv
// serial_tx: UART-style serial transmitter.
// Frame: one low start bit, DATA_W payload bits in LSB_FIRST order,
// an optional parity bit, then STOP_BITS high stop bits. Each bit is
// held for CLKS_PER_BIT cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN adds one parity bit after the
// payload. The bit is even parity, or odd parity when PARITY_ODD=1.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              serial_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_MAX = 1'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    // Illegal parameter values are rejected when the design is elaborated.
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("serial_tx: DATA_W must be 1..32");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks
        $error("serial_tx: CLKS_PER_BIT must be >= 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("serial_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("serial_tx: PARITY_ODD must be 0 or 1");
    end

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic [DATA_W-1:0] shreg;
    logic              data_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_bit;

    // The parity bit makes the total count of ones even.
    // With PARITY_ODD=1 the bit is inverted, so the total count is odd.
    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction
`endif

    // Advance the shift register so the next payload bit sits at the output end.
    function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
        if (LSB_FIRST != 0) begin
            return v >> 1;
        end
        return v << 1;
    endfunction

    assign data_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1];
    assign ready_o  = (state == IDLE);
    assign busy_o   = (state != IDLE);

    // Drive the serial line from the current state. The line is high whenever no frame is being sent.
    always_comb begin
        serial_o = 1'b1;
        case (state)
            START:  serial_o = 1'b0;
            DATA:   serial_o = data_bit;
`ifdef SERIAL_TX_PARITY_EN
            PARITY: serial_o = parity_bit;
`endif
            default: serial_o = 1'b1;
        endcase
    end

    // Frame sequencer: handshake capture, per-bit down-counter, state advance, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            done_o     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        shreg      <= data_i;
                        cnt        <= CNT_MAX;
                        stop_cnt   <= STOP_MAX;
                        state      <= START;
`ifdef SERIAL_TX_PARITY_EN
                        parity_bit <= calc_parity(data_i);
`endif
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt     <= CNT_MAX;
                        bit_cnt <= IDX_MAX;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_MAX;
                        shreg <= shift_next(shreg);
                        if (bit_cnt == '0) begin
`ifdef SERIAL_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_MAX;
                        state <= STOP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0) begin
                        if (stop_cnt == 1'b0) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b0;
                            cnt      <= CNT_MAX;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
